comparator_2bit: RTL and testbench

- Registered magnitude comparator for two small unsigned operands.
- Classifies A_in relative to B_in as greater, equal or less, using mutually exclusive one-hot flags.
- Outputs are registered with a valid strobe.
- Used as a leaf block wherever a clocked two-bit compare result feeds downstream control logic.

---
 rtl/comparator_2bit.sv | 65 ++++++
 tb/tb_comparator_2bit.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/comparator_2bit.sv
// Registered magnitude comparator: one-hot greater/equal/less flags plus a valid strobe.
// Latency 1 clock; no backpressure, one compare per clock, flags hold while in_valid is low.
module comparator_2bit #(
    parameter int WIDTH  = 2,
    parameter bit SIGNED = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] A_in,
    input  logic [WIDTH-1:0] B_in,
    output logic             is_greater,
    output logic             is_equal,
    output logic             is_less,
    output logic             out_valid
);

    // Inverting the MSB maps two's-complement order onto unsigned order,
    // so one unsigned comparator serves both modes.
    localparam logic [WIDTH-1:0] SIGN_FLIP = SIGNED ? (WIDTH'(1) << (WIDTH - 1)) : '0;

    logic [WIDTH-1:0] a_cmp;
    logic [WIDTH-1:0] b_cmp;
    logic             greater_d, greater_q;
    logic             equal_d,   equal_q;
    logic             less_d,    less_q;
    logic             valid_d,   valid_q;

    assign a_cmp = A_in ^ SIGN_FLIP;
    assign b_cmp = B_in ^ SIGN_FLIP;

    // Operands are only looked at when in_valid is high, so idle X/Z cannot leak.
    always_comb begin
        greater_d = greater_q;
        equal_d   = equal_q;
        less_d    = less_q;
        valid_d   = 1'b0;
        if (in_valid) begin
            greater_d = (a_cmp > b_cmp);
            equal_d   = (a_cmp == b_cmp);
            less_d    = (a_cmp < b_cmp);
            valid_d   = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            greater_q <= 1'b0;
            equal_q   <= 1'b0;
            less_q    <= 1'b0;
            valid_q   <= 1'b0;
        end else begin
            greater_q <= greater_d;
            equal_q   <= equal_d;
            less_q    <= less_d;
            valid_q   <= valid_d;
        end
    end

    assign is_greater = greater_q;
    assign is_equal   = equal_q;
    assign is_less    = less_q;
    assign out_valid  = valid_q;

endmodule

// File: tb/tb_comparator_2bit.sv
// Bench for comparator_2bit: unsigned and signed instances driven in parallel,
// checked against fixed vector tables and an integer-arithmetic reference model.
module tb_comparator_2bit;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic [1:0] a_in = '0;
    logic [1:0] b_in = '0;

    logic u_g, u_e, u_l, u_v;
    logic s_g, s_e, s_l, s_v;

    int checks   = 0;
    int failures = 0;

    logic [2:0] exp_u = '0;
    logic [2:0] exp_s = '0;
    logic       exp_v = 1'b0;

    always #5 clk = ~clk;

    comparator_2bit #(.WIDTH(2), .SIGNED(1'b0)) dut_u (
        .clk(clk), .rst(rst), .in_valid(in_valid), .A_in(a_in), .B_in(b_in),
        .is_greater(u_g), .is_equal(u_e), .is_less(u_l), .out_valid(u_v)
    );

    comparator_2bit #(.WIDTH(2), .SIGNED(1'b1)) dut_s (
        .clk(clk), .rst(rst), .in_valid(in_valid), .A_in(a_in), .B_in(b_in),
        .is_greater(s_g), .is_equal(s_e), .is_less(s_l), .out_valid(s_v)
    );

    // Reference: plain integer compare, with sign interpretation for signed mode.
    function automatic logic [2:0] ref_cmp(input logic [1:0] a, input logic [1:0] b, input bit sgn);
        int x;
        int y;
        x = int'(a);
        y = int'(b);
        if (sgn) begin
            if (x >= 2) x = x - 4;
            if (y >= 2) y = y - 4;
        end
        return {x > y, x == y, x < y};
    endfunction

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got gelv=%b expected gelv=%b", name, act, exp);
        end
    endtask

    // Apply one cycle of stimulus, advance the model, check both instances after the edge.
    task automatic step(input bit r, input bit v, input logic [1:0] a, input logic [1:0] b,
                        input string tag);
        rst      = r;
        in_valid = v;
        a_in     = a;
        b_in     = b;
        @(posedge clk);
        #1;
        if (r) begin
            exp_u = '0;
            exp_s = '0;
            exp_v = 1'b0;
        end else if (v) begin
            exp_u = ref_cmp(a, b, 1'b0);
            exp_s = ref_cmp(a, b, 1'b1);
            exp_v = 1'b1;
        end else begin
            exp_v = 1'b0;
        end
        check({tag, "_unsigned"}, {u_g, u_e, u_l, u_v}, {exp_u, exp_v});
        check({tag, "_signed"},   {s_g, s_e, s_l, s_v}, {exp_s, exp_v});
    endtask

    typedef struct {
        logic [1:0] a;
        logic [1:0] b;
        logic [2:0] gel_u;
        logic [2:0] gel_s;
    } vec_t;

    localparam logic [2:0] GT = 3'b100;
    localparam logic [2:0] EQ = 3'b010;
    localparam logic [2:0] LT = 3'b001;

    vec_t tbl[9];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{2'b00, 2'b00, EQ, EQ};
        tbl[1] = '{2'b01, 2'b00, GT, GT};
        tbl[2] = '{2'b10, 2'b01, GT, LT};
        tbl[3] = '{2'b11, 2'b10, GT, GT};
        tbl[4] = '{2'b01, 2'b11, LT, GT};
        tbl[5] = '{2'b10, 2'b10, EQ, EQ};
        tbl[6] = '{2'b10, 2'b01, GT, LT};
        tbl[7] = '{2'b11, 2'b10, GT, GT};
        tbl[8] = '{2'b11, 2'b11, EQ, EQ};

        // Reset with a live compare presented: it must be discarded.
        step(1'b1, 1'b1, 2'b11, 2'b00, "reset0");
        step(1'b1, 1'b1, 2'b11, 2'b00, "reset1");
        check("reset_const", {u_g, u_e, u_l, u_v}, 4'b0000);
        step(1'b0, 1'b0, 2'b11, 2'b00, "post_reset_idle0");
        step(1'b0, 1'b0, 2'b01, 2'b10, "post_reset_idle1");

        // Directed sweep, back-to-back, against fixed table expectations.
        for (int i = 0; i < 9; i++) begin
            step(1'b0, 1'b1, tbl[i].a, tbl[i].b, $sformatf("table%0d", i));
            check($sformatf("table%0d_const_u", i), {u_g, u_e, u_l, u_v}, {tbl[i].gel_u, 1'b1});
            check($sformatf("table%0d_const_s", i), {s_g, s_e, s_l, s_v}, {tbl[i].gel_s, 1'b1});
        end

        // Exhaustive, back-to-back: one-hot and continuous out_valid.
        for (int a = 0; a < 4; a++) begin
            for (int b = 0; b < 4; b++) begin
                step(1'b0, 1'b1, 2'(a), 2'(b), $sformatf("exh_%0d_%0d", a, b));
                check($sformatf("onehot_u_%0d_%0d", a, b),
                      {3'b000, $countones({u_g, u_e, u_l}) == 1}, 4'b0001);
                check($sformatf("onehot_s_%0d_%0d", a, b),
                      {3'b000, $countones({s_g, s_e, s_l}) == 1}, 4'b0001);
            end
        end

        // Hold: flags keep the last capture while idle operands change.
        step(1'b0, 1'b1, 2'b01, 2'b11, "hold_cap");
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 1'b0, 2'b11, 2'b00, $sformatf("hold%0d", k));
            check($sformatf("hold%0d_const", k), {u_g, u_e, u_l, u_v}, 4'b0010);
        end

        // Mid-stream reset for a single edge, then resume.
        step(1'b0, 1'b1, 2'b11, 2'b01, "mid_pre0");
        step(1'b0, 1'b1, 2'b00, 2'b01, "mid_pre1");
        step(1'b1, 1'b1, 2'b11, 2'b00, "mid_rst");
        check("mid_rst_const", {s_g, s_e, s_l, s_v}, 4'b0000);
        step(1'b0, 1'b1, 2'b10, 2'b11, "mid_resume");
        check("mid_resume_const", {u_g, u_e, u_l, u_v}, 4'b0011);

        // Randomized traffic with occasional resets and idle cycles.
        for (int n = 0; n < 400; n++) begin
            step($urandom_range(0, 24) == 0, $urandom_range(0, 3) != 0,
                 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), $sformatf("rand%0d", n));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
